fp_wb_arbiter: RTL and testbench
================================

// Module: fp_wb_arbiter
// PURPOSE
// Writeback arbiter for the variable-latency FP execution units (add/sub, mul, div/sqrt) of the RV32IMF core.
// Each unit hands a finished result into a 1-entry holding slot. A round-robin arbiter grants one slot per cycle
// to a registered writeback stage, which drives the FP register-file write port.
// That writeback stage also produces the clear (write-enable + rd) consumed by the FP busy/scoreboard registers.
// The pending-rd list feeds the scoreboard's in-flight rd busy checks.
// PARAMETERS
// NUM_UNITS   3   number of FP result producers (slot/requester count)
// DATA_W      32  FP result width
// REG_ADDR_W  5   FP register address width
// FLAGS_W     5   IEEE exception flags width (NV,DZ,OF,UF,NX)
// PORTS
// clk               in   1                    core clock, rising edge
// reset_n           in   1                    asynchronous active-low reset
// unit_valid        in   NUM_UNITS            unit i presents a finished result
// unit_rd           in   REG_ADDR_W x NUM     destination FP register per unit
// unit_data         in   DATA_W x NUM         result value per unit
// unit_fflags       in   FLAGS_W x NUM        exception flags per unit
// unit_ready        out  NUM_UNITS            slot i can accept this cycle
// FP_reg_write_p_mux out 1                    writeback valid (FP regfile write enable / scoreboard clear)
// waddr_wb          out  REG_ADDR_W           writeback destination register
// wdata_wb          out  DATA_W               writeback data
// fflags_wb         out  FLAGS_W              flags to OR into fcsr.fflags when FP_reg_write_p_mux=1
// all_uu_FP_rd      out  REG_ADDR_W x NUM     rd held in each slot
// all_uu_FP_valid   out  NUM_UNITS            slot i occupied
// BEHAVIOUR
// - Reset (async, reset_n=0):
//   - all slots empty; RR pointer = 0
//   - FP_reg_write_p_mux=0; waddr_wb, wdata_wb, fflags_wb = 0
//   - unit_ready = all ones (combinational from empty slots)
//   - reset mid-operation discards pending results without writeback
// - Slots: slot i = {valid, rd, data, fflags}.
//   - unit_ready[i] = ~slot_valid[i] | grant[i] (combinational)
//   - On unit_valid[i] & unit_ready[i], the slot loads at the clock edge.
//   - unit_valid with ready=0: the unit must hold its outputs stable; nothing is lost.
// - Arbitration (combinational, among slot_valid):
//   - Search starts at the RR pointer, upward with wrap: NUM-1 -> 0.
//   - At most one grant per cycle; grant is one-hot or zero.
//   - Pointer <= (granted index + 1) mod NUM_UNITS on a grant; unchanged when nothing is granted.
// - Granted slot, in the same edge:
//   - copies into the writeback register (FP_reg_write_p_mux<=1, waddr/wdata/fflags <= slot)
//   - clears, unless simultaneously reloaded by its unit (same-edge refill allowed, no bubble)
// - No grant: FP_reg_write_p_mux<=0; waddr/wdata/fflags hold their previous values.
// - Latency: unit_valid at edge N -> slot at N+1 -> writeback outputs valid after edge N+2, when uncontended.
// - Throughput: 1 writeback/cycle total. A single active unit sustains 1 result/cycle.
// - Contention: all slots full -> each is served within NUM_UNITS cycles (starvation-free).
// - Same rd in two slots: both are written, in grant order. The scoreboard's single busy bit per reg clears on the first.
//   Issue logic (WAW stall) prevents this case; the arbiter does not check for it.
// - f0 is a normal FP register: no address filtering.
// - all_uu_FP_rd / all_uu_FP_valid are direct slot register outputs, with no combinational path from inputs.
// TESTING
// 1. Reset then idle:
//    - FP_reg_write_p_mux=0, unit_ready=3'b111, all_uu_FP_valid=0 for 10 cycles.
// 2. Single result:
//    - unit1 valid 1 cycle, rd=5, data=32'h3F800000, fflags=5'b00001
//    - -> 2 cycles later FP_reg_write_p_mux=1 for exactly 1 cycle with waddr_wb=5, wdata_wb=32'h3F800000, fflags_wb=1.
// 3. Three-way contention:
//    - units 0,1,2 valid in the same cycle (rd 1,2,3), pointer=0
//    - -> writebacks rd 1,2,3 on consecutive cycles
//    - unit_ready low while each slot waits; pointer ends at 0.
// 4. Fairness:
//    - unit0 and unit2 valid every cycle for 20 cycles
//    - -> writebacks alternate 0,2,0,2...; neither unit waits more than 1 cycle; no data lost.
// 5. Back-to-back refill:
//    - unit0 alone, valid every cycle, rd 8..15
//    - -> unit_ready[0] stays 1; 8 consecutive writebacks rd 8..15, in order, with no bubble.
// 6. Reset mid-operation:
//    - all slots full; assert reset_n=0 between edges
//    - -> FP_reg_write_p_mux=0 and all_uu_FP_valid=0 immediately; no writeback after release.

Source files
------------

// File: rtl/fp_wb_arbiter_if.sv
// Handshake/bus bundle between the FP execution units, the writeback arbiter and the
// FP register file / scoreboard consumers.
interface fp_wb_arbiter_if #(
  parameter int unsigned NUM_UNITS  = 3,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FLAGS_W    = 5
);
  logic [NUM_UNITS-1:0]                 unit_valid;
  logic [NUM_UNITS-1:0][REG_ADDR_W-1:0] unit_rd;
  logic [NUM_UNITS-1:0][DATA_W-1:0]     unit_data;
  logic [NUM_UNITS-1:0][FLAGS_W-1:0]    unit_fflags;
  logic [NUM_UNITS-1:0]                 unit_ready;
  logic                                 FP_reg_write_p_mux;
  logic [REG_ADDR_W-1:0]                waddr_wb;
  logic [DATA_W-1:0]                    wdata_wb;
  logic [FLAGS_W-1:0]                   fflags_wb;
  logic [NUM_UNITS-1:0][REG_ADDR_W-1:0] all_uu_FP_rd;
  logic [NUM_UNITS-1:0]                 all_uu_FP_valid;

  modport master (
    output unit_valid, unit_rd, unit_data, unit_fflags,
    input  unit_ready, FP_reg_write_p_mux, waddr_wb, wdata_wb, fflags_wb,
    input  all_uu_FP_rd, all_uu_FP_valid
  );

  modport slave (
    input  unit_valid, unit_rd, unit_data, unit_fflags,
    output unit_ready, FP_reg_write_p_mux, waddr_wb, wdata_wb, fflags_wb,
    output all_uu_FP_rd, all_uu_FP_valid
  );
endinterface

// File: rtl/fp_wb_arbiter.sv
// Writeback arbiter for the FP execution units: one holding slot per unit, round-robin
// grant of one slot per cycle into a registered FP register-file write stage.
module fp_wb_arbiter #(
  parameter int unsigned NUM_UNITS  = 3,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FLAGS_W    = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  fp_wb_arbiter_if.slave bus
);
  localparam int unsigned PtrW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0]                 slot_valid_q, slot_valid_d;
  logic [NUM_UNITS-1:0][REG_ADDR_W-1:0] slot_rd_q, slot_rd_d;
  logic [NUM_UNITS-1:0][DATA_W-1:0]     slot_data_q, slot_data_d;
  logic [NUM_UNITS-1:0][FLAGS_W-1:0]    slot_fflags_q, slot_fflags_d;
  logic [PtrW-1:0]                      rr_ptr_q, rr_ptr_d;

  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic [FLAGS_W-1:0]    wb_fflags_q, wb_fflags_d;

  logic [NUM_UNITS-1:0] grant;
  logic [NUM_UNITS-1:0] load;
  logic [PtrW-1:0]      gnt_idx;
  logic [PtrW-1:0]      cand;
  logic                 found;

  // Round-robin search starting at the pointer, wrapping past the top slot.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      cand = PtrW'((32'(rr_ptr_q) + k) % NUM_UNITS);
      if (!found && slot_valid_q[cand]) begin
        found        = 1'b1;
        grant[cand]  = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  assign bus.unit_ready = ~slot_valid_q | grant;
  assign load           = bus.unit_valid & bus.unit_ready;

  always_comb begin
    slot_valid_d  = slot_valid_q;
    slot_rd_d     = slot_rd_q;
    slot_data_d   = slot_data_q;
    slot_fflags_d = slot_fflags_q;
    rr_ptr_d      = rr_ptr_q;
    wb_valid_d    = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    wb_fflags_d   = wb_fflags_q;

    if (found) begin
      wb_valid_d  = 1'b1;
      wb_addr_d   = slot_rd_q[gnt_idx];
      wb_data_d   = slot_data_q[gnt_idx];
      wb_fflags_d = slot_fflags_q[gnt_idx];
      rr_ptr_d    = (gnt_idx == PtrW'(NUM_UNITS - 1)) ? '0 : gnt_idx + PtrW'(1);
    end

    // A granted slot refilled on the same edge stays occupied, so no bubble.
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      slot_valid_d[i] = load[i] | (slot_valid_q[i] & ~grant[i]);
      if (load[i]) begin
        slot_rd_d[i]     = bus.unit_rd[i];
        slot_data_d[i]   = bus.unit_data[i];
        slot_fflags_d[i] = bus.unit_fflags[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q  <= '0;
      slot_rd_q     <= '0;
      slot_data_q   <= '0;
      slot_fflags_q <= '0;
      rr_ptr_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      wb_fflags_q   <= '0;
    end else begin
      slot_valid_q  <= slot_valid_d;
      slot_rd_q     <= slot_rd_d;
      slot_data_q   <= slot_data_d;
      slot_fflags_q <= slot_fflags_d;
      rr_ptr_q      <= rr_ptr_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      wb_fflags_q   <= wb_fflags_d;
    end
  end

  assign bus.FP_reg_write_p_mux = wb_valid_q;
  assign bus.waddr_wb           = wb_addr_q;
  assign bus.wdata_wb           = wb_data_q;
  assign bus.fflags_wb          = wb_fflags_q;
  assign bus.all_uu_FP_rd       = slot_rd_q;
  assign bus.all_uu_FP_valid    = slot_valid_q;
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Randomized and directed bench for fp_wb_arbiter against a cycle-level behavioural model
// of slots, round-robin pointer and writeback register.
module tb_fp_wb_arbiter;
  localparam int N = 3;

  logic clk;
  logic reset_n;

  fp_wb_arbiter_if #(.NUM_UNITS(N), .DATA_W(32), .REG_ADDR_W(5), .FLAGS_W(5)) bus ();

  fp_wb_arbiter #(.NUM_UNITS(N), .DATA_W(32), .REG_ADDR_W(5), .FLAGS_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  bit          m_valid [N];
  logic [4:0]  m_rd    [N];
  logic [31:0] m_data  [N];
  logic [4:0]  m_fl    [N];
  int          m_ptr;
  bit          m_wb_v;
  logic [4:0]  m_wb_a;
  logic [31:0] m_wb_d;
  logic [4:0]  m_wb_f;

  // Unit sources: a pending result is held stable until accepted
  bit          u_pend [N];
  logic [4:0]  u_rd   [N];
  logic [31:0] u_data [N];
  logic [4:0]  u_fl   [N];
  int          seq_rd = -1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_rd[i] = '0; m_data[i] = '0; m_fl[i] = '0; u_pend[i] = 0;
    end
    m_ptr = 0; m_wb_v = 0; m_wb_a = '0; m_wb_d = '0; m_wb_f = '0;
  endtask

  task automatic compare_outputs();
    logic [N-1:0]     ev;
    logic [N*5-1:0]   er;
    for (int i = 0; i < N; i++) begin
      ev[i]          = m_valid[i];
      er[i*5 +: 5]   = m_rd[i];
    end
    check_eq("wb_valid", 64'(bus.FP_reg_write_p_mux), 64'(m_wb_v));
    check_eq("waddr_wb", 64'(bus.waddr_wb), 64'(m_wb_a));
    check_eq("wdata_wb", 64'(bus.wdata_wb), 64'(m_wb_d));
    check_eq("fflags_wb", 64'(bus.fflags_wb), 64'(m_wb_f));
    check_eq("slot_valid", 64'(bus.all_uu_FP_valid), 64'(ev));
    check_eq("slot_rd", 64'(bus.all_uu_FP_rd), 64'(er));
  endtask

  // One cycle: check state, drive inputs, check ready, advance model across the coming edge.
  task automatic tick(input int p0, input int p1, input int p2);
    int          p [N];
    int          g;
    logic [N-1:0] exp_rdy;
    bit          acc [N];
    p[0] = p0; p[1] = p1; p[2] = p2;
    @(negedge clk);
    compare_outputs();
    for (int i = 0; i < N; i++) begin
      if (!u_pend[i] && int'($urandom_range(99)) < p[i]) begin
        u_pend[i] = 1;
        u_rd[i]   = 5'($urandom);
        u_data[i] = $urandom;
        u_fl[i]   = 5'($urandom);
        if (i == 0 && seq_rd >= 0) begin
          u_rd[i] = 5'(seq_rd);
          seq_rd++;
        end
      end
      bus.unit_valid[i]  = u_pend[i];
      bus.unit_rd[i]     = u_rd[i];
      bus.unit_data[i]   = u_data[i];
      bus.unit_fflags[i] = u_fl[i];
    end
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && m_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) exp_rdy[i] = !m_valid[i] || (g == i);
    #1;
    check_eq("unit_ready", 64'(bus.unit_ready), 64'(exp_rdy));
    for (int i = 0; i < N; i++) acc[i] = u_pend[i] && exp_rdy[i];
    if (g >= 0) begin
      m_wb_v = 1; m_wb_a = m_rd[g]; m_wb_d = m_data[g]; m_wb_f = m_fl[g];
      m_valid[g] = 0;
      m_ptr = (g + 1) % N;
    end else begin
      m_wb_v = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        m_valid[i] = 1; m_rd[i] = u_rd[i]; m_data[i] = u_data[i]; m_fl[i] = u_fl[i];
        u_pend[i]  = 0;
      end
    end
  endtask

  task automatic load_unit(input int i, input logic [4:0] rd, input logic [31:0] d,
                           input logic [4:0] f);
    u_pend[i] = 1; u_rd[i] = rd; u_data[i] = d; u_fl[i] = f;
  endtask

  // Assert reset between edges and check that it takes effect without a clock.
  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_wb_valid", 64'(bus.FP_reg_write_p_mux), 64'h0);
    check_eq("rst_slot_valid", 64'(bus.all_uu_FP_valid), 64'h0);
    check_eq("rst_ready", 64'(bus.unit_ready), 64'h7);
    check_eq("rst_waddr", 64'(bus.waddr_wb), 64'h0);
    check_eq("rst_wdata", 64'(bus.wdata_wb), 64'h0);
    bus.unit_valid = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.unit_valid  = '0;
    bus.unit_rd     = '0;
    bus.unit_data   = '0;
    bus.unit_fflags = '0;
    model_reset();
    #12;
    check_eq("init_wb_valid", 64'(bus.FP_reg_write_p_mux), 64'h0);
    check_eq("init_ready", 64'(bus.unit_ready), 64'h7);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset
    repeat (10) tick(0, 0, 0);

    // Single result from unit 1
    load_unit(1, 5'd5, 32'h3F80_0000, 5'b00001);
    repeat (4) tick(0, 0, 0);

    // Three-way contention from pointer 0
    do_reset();
    load_unit(0, 5'd1, 32'h1111_1111, 5'd1);
    load_unit(1, 5'd2, 32'h2222_2222, 5'd2);
    load_unit(2, 5'd3, 32'h3333_3333, 5'd3);
    repeat (6) tick(0, 0, 0);

    // Fairness between units 0 and 2
    repeat (20) tick(100, 0, 100);
    repeat (4) tick(0, 0, 0);

    // Back-to-back refill of unit 0 with rd 8..15
    do_reset();
    seq_rd = 8;
    repeat (8) tick(100, 0, 0);
    seq_rd = -1;
    repeat (4) tick(0, 0, 0);

    // Random traffic
    repeat (150) tick(50, 50, 50);
    repeat (150) tick(90, 30, 70);

    // Reset with all slots full
    repeat (4) tick(100, 100, 100);
    do_reset();
    repeat (5) tick(0, 0, 0);
    repeat (40) tick(60, 60, 60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
